// File: rtl/i2c_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared i2c_master.
// The master modport is the arbiter's view; slave is the requester/master-side environment.
interface i2c_bus_arbiter_if;
   logic [1:0] req;
   logic [1:0] grant;
   logic [1:0] done;
   logic       timeout;

   logic [7:0] r0_nbytes;
   logic [6:0] r0_addr;
   logic       r0_rw;
   logic [7:0] r0_write_data;
   logic       r0_tx_data_req;
   logic       r0_rx_data_ready;

   logic [7:0] r1_nbytes;
   logic [6:0] r1_addr;
   logic       r1_rw;
   logic [7:0] r1_write_data;
   logic       r1_tx_data_req;
   logic       r1_rx_data_ready;

   logic [7:0] r_read_data;

   logic       m_start;
   logic [7:0] m_nbytes;
   logic [6:0] m_addr;
   logic       m_rw;
   logic [7:0] m_write_data;
   logic [7:0] m_read_data;
   logic       m_tx_data_req;
   logic       m_rx_data_ready;
   logic       m_busy;

   modport master (
      input  req,
      input  r0_nbytes, r0_addr, r0_rw, r0_write_data,
      input  r1_nbytes, r1_addr, r1_rw, r1_write_data,
      input  m_read_data, m_tx_data_req, m_rx_data_ready, m_busy,
      output grant, done, timeout,
      output r0_tx_data_req, r0_rx_data_ready,
      output r1_tx_data_req, r1_rx_data_ready,
      output r_read_data,
      output m_start, m_nbytes, m_addr, m_rw, m_write_data
   );

   modport slave (
      output req,
      output r0_nbytes, r0_addr, r0_rw, r0_write_data,
      output r1_nbytes, r1_addr, r1_rw, r1_write_data,
      output m_read_data, m_tx_data_req, m_rx_data_ready, m_busy,
      input  grant, done, timeout,
      input  r0_tx_data_req, r0_rx_data_ready,
      input  r1_tx_data_req, r1_rx_data_ready,
      input  r_read_data,
      input  m_start, m_nbytes, m_addr, m_rw, m_write_data
   );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master between two requesters, one transaction per grant,
// with a guard gap after each transaction and a watchdog that forces release.
module i2c_bus_arbiter #(
   parameter int unsigned GUARD_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic               clk,
   input logic               reset,
   i2c_bus_arbiter_if.master bus
);
   localparam int unsigned   GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic [19:0]   WD_LAST    = 20'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LATCH, START, RUN, GUARD} state_t;

   state_t        state;
   logic          winner;
   logic          last_served;
   logic          pick;
   logic [19:0]   wd_cnt;
   logic [GW-1:0] guard_cnt;

   // Under contention the requester not served last wins.
   always_comb begin
      pick = ~last_served;
      if (bus.req == 2'b01)
         pick = 1'b0;
      else if (bus.req == 2'b10)
         pick = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         winner      <= 1'b0;
         last_served <= 1'b1;
         wd_cnt      <= '0;
         guard_cnt   <= '0;
         bus.grant   <= '0;
         bus.done    <= '0;
         bus.timeout <= 1'b0;
         bus.m_start <= 1'b0;
         bus.m_nbytes <= '0;
         bus.m_addr  <= '0;
         bus.m_rw    <= 1'b0;
      end else begin
         bus.done    <= '0;
         bus.timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|bus.req && !bus.m_busy) begin
                  winner    <= pick;
                  bus.grant <= pick ? 2'b10 : 2'b01;
                  state     <= LATCH;
               end
            end
            LATCH: begin
               bus.m_nbytes <= winner ? bus.r1_nbytes : bus.r0_nbytes;
               bus.m_addr   <= winner ? bus.r1_addr   : bus.r0_addr;
               bus.m_rw     <= winner ? bus.r1_rw     : bus.r0_rw;
               last_served  <= winner;
               wd_cnt       <= '0;
               bus.m_start  <= 1'b1;
               state        <= START;
            end
            START, RUN: begin
               // The watchdog takes priority over both the start handshake and normal completion.
               if (wd_cnt == WD_LAST) begin
                  bus.timeout <= 1'b1;
                  bus.done    <= winner ? 2'b10 : 2'b01;
                  bus.grant   <= '0;
                  bus.m_start <= 1'b0;
                  guard_cnt   <= '0;
                  state       <= GUARD;
               end else begin
                  wd_cnt <= wd_cnt + 20'd1;
                  if (state == START) begin
                     if (bus.m_busy) begin
                        bus.m_start <= 1'b0;
                        state       <= RUN;
                     end
                  end else if (!bus.m_busy) begin
                     bus.done  <= winner ? 2'b10 : 2'b01;
                     bus.grant <= '0;
                     guard_cnt <= '0;
                     state     <= GUARD;
                  end
               end
            end
            GUARD: begin
               if (guard_cnt == GUARD_LAST)
                  state <= IDLE;
               else
                  guard_cnt <= guard_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.r0_tx_data_req   = bus.m_tx_data_req   & bus.grant[0];
   assign bus.r1_tx_data_req   = bus.m_tx_data_req   & bus.grant[1];
   assign bus.r0_rx_data_ready = bus.m_rx_data_ready & bus.grant[0];
   assign bus.r1_rx_data_ready = bus.m_rx_data_ready & bus.grant[1];
   assign bus.r_read_data      = bus.m_read_data;
   assign bus.m_write_data     = bus.grant[0] ? bus.r0_write_data :
                                 bus.grant[1] ? bus.r1_write_data : '0;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized scoreboard bench for i2c_bus_arbiter: a transaction-level round-robin model predicts
// grants, and a separate monitor compares each grant/done episode and the strobe routing.
module tb_i2c_bus_arbiter;
   localparam int unsigned G  = 3;
   localparam int unsigned TO = 100;

   typedef struct {
      bit       who;
      bit [6:0] addr;
      bit [7:0] nbytes;
      bit       rw;
      bit       to;
      bit       follow;
      int       gcyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   fails  = 0;

   exp_t expq[$];

   i2c_bus_arbiter_if bus ();

   i2c_bus_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural i2c_master: answers m_start after a short delay, stays busy a while and
   // strobes data; idle noise strobes must be dropped by the arbiter.
   bit mst_hold    = 1'b0;
   bit hold_busy   = 1'b0;
   bit master_dead = 1'b0;
   int mst = 0;
   int dly = 0;
   int len = 0;

   initial begin
      bus.m_busy          = 1'b0;
      bus.m_tx_data_req   = 1'b0;
      bus.m_rx_data_ready = 1'b0;
      bus.m_read_data     = '0;
      bus.r0_write_data   = '0;
      bus.r1_write_data   = '0;
      forever begin
         @(negedge clk);
         #1;
         bus.r0_write_data   = 8'($urandom);
         bus.r1_write_data   = 8'($urandom);
         bus.m_read_data     = 8'($urandom);
         bus.m_tx_data_req   = 1'b0;
         bus.m_rx_data_ready = 1'b0;
         if (mst_hold) begin
            bus.m_busy = hold_busy;
            mst = 0;
         end else begin
            case (mst)
               0: begin
                  bus.m_busy = 1'b0;
                  if (bus.m_start && !master_dead) begin
                     dly = $urandom_range(1, 4);
                     mst = 1;
                  end else if ($urandom_range(0, 7) == 0) begin
                     bus.m_tx_data_req   = 1'b1;
                     bus.m_rx_data_ready = 1'($urandom_range(0, 1));
                  end
               end
               1: begin
                  dly--;
                  if (dly == 0) begin
                     bus.m_busy = 1'b1;
                     len = $urandom_range(3, 15);
                     mst = 2;
                  end
               end
               2: begin
                  bus.m_tx_data_req   = ($urandom_range(0, 2) == 0);
                  bus.m_rx_data_ready = ($urandom_range(0, 2) == 0);
                  len--;
                  if (len == 0) begin
                     bus.m_busy          = 1'b0;
                     bus.m_tx_data_req   = 1'b0;
                     bus.m_rx_data_ready = 1'b0;
                     mst = 0;
                  end
               end
               default: mst = 0;
            endcase
         end
      end
   end

   // Monitor: samples just after each rising edge and checks against popped expectations.
   bit       mon_en = 1'b0;
   bit       in_txn = 1'b0;
   bit       seen_start = 1'b0;
   bit       prev_busy = 1'b0;
   exp_t     cur;
   logic [1:0] oh;
   logic [1:0] hold;
   int       gcyc = 0;
   int       start_cyc = 0;
   int       fall_cyc = 0;
   int       last_done_cyc = 0;
   int       done_seen = 0;

   initial forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
         in_txn    = 1'b0;
         prev_busy = bus.m_busy;
      end else begin
         if (prev_busy && !bus.m_busy)
            fall_cyc = cyc;
         prev_busy = bus.m_busy;
         if (!in_txn && bus.grant != 2'b00) begin
            if (expq.size() == 0) begin
               chk("unexpected_grant", bus.grant, 0);
            end else begin
               cur = expq.pop_front();
               oh  = cur.who ? 2'b10 : 2'b01;
               in_txn     = 1'b1;
               seen_start = 1'b0;
               gcyc       = cyc;
               chk("grant_winner", bus.grant, oh);
               if (cur.follow)
                  chk("regrant_gap", cyc - last_done_cyc, G + 1);
               else
                  chk("grant_latency", cyc, cur.gcyc);
            end
         end else if (in_txn) begin
            if (bus.done != 2'b00) begin
               chk("done_holder", bus.done, oh);
               chk("timeout_flag", bus.timeout, cur.to);
               chk("grant_drop", bus.grant, 0);
               chk("m_addr_kept", bus.m_addr, cur.addr);
               if (cur.to)
                  chk("timeout_delay", cyc - start_cyc, TO);
               else
                  chk("done_delay", cyc - fall_cyc, 0);
               in_txn = 1'b0;
               last_done_cyc = cyc;
               done_seen++;
            end else begin
               chk("grant_held", bus.grant, oh);
               if (bus.m_start && !seen_start) begin
                  seen_start = 1'b1;
                  start_cyc  = cyc;
                  chk("start_delay", cyc - gcyc, 1);
                  chk("m_addr", bus.m_addr, cur.addr);
                  chk("m_nbytes", bus.m_nbytes, cur.nbytes);
                  chk("m_rw", bus.m_rw, cur.rw);
               end
            end
         end else begin
            chk("idle_quiet", {bus.done, bus.timeout, bus.m_start}, 0);
         end
         if (bus.m_busy)
            chk("m_start_after_busy", bus.m_start, 0);
         hold = in_txn ? oh : 2'b00;
         chk("strobes",
             {bus.r1_rx_data_ready, bus.r0_rx_data_ready, bus.r1_tx_data_req, bus.r0_tx_data_req},
             {bus.m_rx_data_ready & hold[1], bus.m_rx_data_ready & hold[0],
              bus.m_tx_data_req & hold[1], bus.m_tx_data_req & hold[0]});
         chk("write_data", bus.m_write_data,
             hold[0] ? bus.r0_write_data : hold[1] ? bus.r1_write_data : 8'h00);
         chk("read_data", bus.r_read_data, bus.m_read_data);
      end
   end

   // Stimulus and reference model.
   logic [6:0] addr_v[2];
   logic [7:0] nb_v[2];
   logic       rw_v[2];
   bit         last_srv;
   bit         abort = 1'b0;

   task automatic drive_fields();
      bus.r0_addr   = addr_v[0];
      bus.r0_nbytes = nb_v[0];
      bus.r0_rw     = rw_v[0];
      bus.r1_addr   = addr_v[1];
      bus.r1_nbytes = nb_v[1];
      bus.r1_rw     = rw_v[1];
   endtask

   task automatic push_exp(input bit w, input bit to, input bit follow);
      exp_t e;
      e.who    = w;
      e.addr   = addr_v[w];
      e.nbytes = nb_v[w];
      e.rw     = rw_v[w];
      e.to     = to;
      e.follow = follow;
      e.gcyc   = cyc + 1;
      expq.push_back(e);
   endtask

   task automatic wait_done(input int tgt, output bit ok);
      int k = 0;
      while (done_seen < tgt && k < 400) begin
         @(negedge clk);
         k++;
      end
      ok = (done_seen >= tgt);
      if (!ok)
         chk("done_wait", done_seen, tgt);
   endtask

   initial begin
      bit ok;
      bus.req = 2'b00;
      for (int unsigned i = 0; i < 2; i++) begin
         addr_v[i] = 7'($urandom);
         nb_v[i]   = 8'($urandom);
         rw_v[i]   = 1'($urandom);
      end
      drive_fields();
      repeat (3) @(negedge clk);
      chk("rst_grant", bus.grant, 0);
      chk("rst_done_timeout", {bus.done, bus.timeout}, 0);
      chk("rst_m_start", bus.m_start, 0);
      chk("rst_m_cmd", {bus.m_nbytes, bus.m_addr, bus.m_rw}, 0);
      reset    = 1'b0;
      mon_en   = 1'b1;
      last_srv = 1'b1;

      for (int r = 0; r < 40 && !abort; r++) begin
         int  pat;
         int  base;
         bit  w;
         bit  dead;
         bit  perturb;
         pat = (r == 0) ? 3 : $urandom_range(1, 3);
         for (int unsigned i = 0; i < 2; i++) begin
            addr_v[i] = 7'($urandom);
            nb_v[i]   = (($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
            rw_v[i]   = 1'($urandom);
         end
         drive_fields();
         dead    = (pat != 3) && ($urandom_range(0, 4) == 0);
         perturb = ($urandom_range(0, 1) == 1);
         master_dead = dead;
         w = (pat == 1) ? 1'b0 : (pat == 2) ? 1'b1 : ~last_srv;
         push_exp(w, dead, 1'b0);
         last_srv = w;
         if (pat == 3) begin
            push_exp(~w, 1'b0, 1'b1);
            last_srv = ~w;
         end
         base = done_seen;
         bus.req = 2'(pat);
         if (perturb && !dead) begin
            for (int k = 0; k < 60 && !bus.m_busy; k++)
               @(negedge clk);
            if (bus.m_busy) begin
               if (w) bus.r1_addr = addr_v[1] ^ 7'h01;
               else   bus.r0_addr = addr_v[0] ^ 7'h01;
               bus.req[w] = 1'b0;
            end
         end
         wait_done(base + 1, ok);
         bus.req[w] = 1'b0;
         master_dead = 1'b0;
         if (!ok) abort = 1'b1;
         if (pat == 3 && !abort) begin
            wait_done(base + 2, ok);
            if (!ok) abort = 1'b1;
         end
         bus.req = 2'b00;
         repeat (G + 2) @(negedge clk);
      end

      if (!abort) begin
         mon_en = 1'b0;
         chk("queue_empty", expq.size(), 0);
         // Foreign activity on the bus blocks any grant.
         mst_hold  = 1'b1;
         hold_busy = 1'b1;
         @(negedge clk);
         bus.req = 2'b01;
         repeat (4) begin
            @(negedge clk);
            chk("busy_idle_nogrant", bus.grant, 0);
         end
         hold_busy = 1'b0;
         @(negedge clk);
         chk("grant_after_busy_falls", bus.grant, 2'b01);
         @(negedge clk);
         chk("direct_m_start", bus.m_start, 1);
         chk("direct_m_addr", bus.m_addr, addr_v[0]);
         hold_busy = 1'b1;
         @(negedge clk);
         chk("direct_run_start_low", bus.m_start, 0);
         reset     = 1'b1;
         hold_busy = 1'b0;
         bus.req   = 2'b00;
         @(negedge clk);
         chk("midrun_reset_grant", bus.grant, 0);
         chk("midrun_reset_start", bus.m_start, 0);
         chk("midrun_reset_pulses", {bus.done, bus.timeout}, 0);
         chk("midrun_reset_addr", bus.m_addr, 0);
         reset = 1'b0;
         addr_v[1] = 7'h51;
         nb_v[1]   = 8'h03;
         rw_v[1]   = 1'b0;
         drive_fields();
         bus.req = 2'b10;
         @(negedge clk);
         chk("fresh_grant_r1", bus.grant, 2'b10);
         @(negedge clk);
         chk("fresh_m_start", bus.m_start, 1);
         chk("fresh_m_cmd", {bus.m_nbytes, bus.m_addr, bus.m_rw}, {8'h03, 7'h51, 1'b0});
         mst_hold = 1'b0;
         begin
            int k = 0;
            while (bus.done == 2'b00 && k < 200) begin
               @(negedge clk);
               k++;
            end
         end
         chk("fresh_done", bus.done, 2'b10);
         chk("fresh_no_timeout", bus.timeout, 0);
         bus.req = 2'b00;
         repeat (G + 2) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL global_time_limit: got cycle %0d, expected completion earlier", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
